// File: rtl/flatten_l2_if.sv
// Shared memory-port bundle between the flatten stage and the layer memories.
interface flatten_l2_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/flatten_l2.sv
// Layer-2 flatten: interleaves two pooled maps into L2[2i]=K0[i], L2[2i+1]=K1[i],
// one read/write per cycle over the shared memory port.
module flatten_l2 #(
  parameter int       DW     = 20,
  parameter int       AW     = 12,
  parameter int       N_PIX  = 1024,
  parameter logic [2:0] SEL_K0 = 3'b011,
  parameter logic [2:0] SEL_K1 = 3'b100,
  parameter logic [2:0] SEL_L2 = 3'b101
) (
  input  logic         clk,
  input  logic         reset,
  flatten_l2_if.master bus
);
  localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PIX - 1);

  typedef enum logic [2:0] {IDLE, RD_K0, RD_K1, WR_K0, WR_K1, FIN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [DW-1:0] d0, d1;

  // Outputs are registered one state ahead: each arm sets up the bus for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      d0           <= '0;
      d1           <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.crd      <= 1'b0;
      bus.cwr      <= 1'b0;
      bus.csel     <= 3'b000;
      bus.caddr_rd <= '0;
      bus.caddr_wr <= '0;
      bus.cdata_wr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy     <= 1'b1;
            idx          <= '0;
            bus.crd      <= 1'b1;
            bus.csel     <= SEL_K0;
            bus.caddr_rd <= '0;
            state        <= RD_K0;
          end
        end
        RD_K0: begin
          d0           <= bus.cdata_rd;
          bus.csel     <= SEL_K1;
          bus.caddr_rd <= AW'(idx);
          state        <= RD_K1;
        end
        RD_K1: begin
          d1           <= bus.cdata_rd;
          bus.crd      <= 1'b0;
          bus.cwr      <= 1'b1;
          bus.csel     <= SEL_L2;
          bus.caddr_wr <= AW'({idx, 1'b0});
          bus.cdata_wr <= d0;
          state        <= WR_K0;
        end
        WR_K0: begin
          bus.caddr_wr <= AW'({idx, 1'b1});
          bus.cdata_wr <= d1;
          state        <= WR_K1;
        end
        WR_K1: begin
          bus.cwr <= 1'b0;
          if (idx == LAST) begin
            bus.csel <= 3'b000;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= FIN;
          end else begin
            idx          <= idx + 1'b1;
            bus.crd      <= 1'b1;
            bus.csel     <= SEL_K0;
            bus.caddr_rd <= AW'(idx) + AW'(1);
            state        <= RD_K0;
          end
        end
        FIN: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
